// File: rtl/fdsync_pkg.sv
// Shared types and helpers for the fdsync double-buffered register family.
// Lane count, lane-enable to bit-mask expansion and FSM state encoding.
package fdsync_pkg;

    localparam int MAX_W = 256;

    typedef logic [MAX_W-1:0] wide_t;

    typedef enum logic {
        FS_IDLE    = 1'b0,
        FS_PENDING = 1'b1
    } fs_state_e;

    function automatic int lanes(int width, int lane_w);
        return (width + lane_w - 1) / lane_w;
    endfunction

    // The top lane may be partial; bits at or above width stay clear.
    function automatic wide_t lane_mask(
        int    nl,
        int    width,
        int    lane_w,
        wide_t lane_en
    );
        wide_t m;
        m = '0;
        for (int b = 0; b < MAX_W; b++) begin
            if (b < width && (b / lane_w) < nl) begin
                m[b] = lane_en[b / lane_w];
            end
        end
        return m;
    endfunction

endpackage

// File: rtl/fdsync_lane_mask.sv
// Expands per-lane write enables into a per-bit write mask.
// Pure combinational; shared by the byte-writable register blocks.
module fdsync_lane_mask
    import fdsync_pkg::*;
#(
    parameter int WIDTH  = 24,
    parameter int LANE_W = 8,
    parameter int NL     = lanes(WIDTH, LANE_W)
) (
    input  logic [NL-1:0]    lane_en,
    output logic [WIDTH-1:0] mask
);

    assign mask = WIDTH'(lane_mask(NL, WIDTH, LANE_W, wide_t'(lane_en)));

endmodule

// File: rtl/fdsync_shadow.sv
// Double-buffered sync register: lane writes land in a shadow copy that
// moves to q atomically on a rising edge of the sync level.
module fdsync_shadow
    import fdsync_pkg::*;
#(
    parameter int               WIDTH     = 24,
    parameter int               LANE_W    = 8,
    parameter logic [WIDTH-1:0] RESET_VAL = '0,
    parameter bit               IMMEDIATE = 1'b0,
    localparam int              NL        = lanes(WIDTH, LANE_W)
) (
    input  logic             sys_clk,
    input  logic             reset,
    input  logic             ld,
    input  logic [NL-1:0]    lane_en,
    input  logic [WIDTH-1:0] d,
    input  logic             sync,
    input  logic             hold,
    output logic [WIDTH-1:0] q,
    output logic [WIDTH-1:0] shadow,
    output logic             pending,
    output logic             xfer
);

    fs_state_e        state;
    fs_state_e        state_nxt;
    logic [WIDTH-1:0] mask;
    logic [WIDTH-1:0] merged;
    logic             wr;
    logic             sync_d;
    logic             sync_rise;
    logic             deferred;
    logic             defer_set;
    logic             fire;

    fdsync_lane_mask #(
        .WIDTH  (WIDTH),
        .LANE_W (LANE_W),
        .NL     (NL)
    ) u_mask (
        .lane_en (lane_en),
        .mask    (mask)
    );

    assign wr        = ld & (|lane_en);
    assign merged    = wr ? ((shadow & ~mask) | (d & mask)) : shadow;
    assign sync_rise = sync & ~sync_d;

    // A rise seen under hold is remembered and replayed once hold drops.
    assign defer_set = !IMMEDIATE && (state == FS_PENDING)
                       && hold && sync_rise;
    assign fire      = !IMMEDIATE && (state == FS_PENDING)
                       && !hold && (sync_rise || deferred);

    always_comb begin
        state_nxt = state;
        if (IMMEDIATE) begin
            state_nxt = FS_IDLE;
        end else if (fire) begin
            state_nxt = FS_IDLE;
        end else if (wr) begin
            state_nxt = FS_PENDING;
        end
    end

    always_ff @(posedge sys_clk or posedge reset) begin
        if (reset) begin
            sync_d <= 1'b1;
        end else begin
            sync_d <= sync;
        end
    end

    always_ff @(posedge sys_clk or posedge reset) begin
        if (reset) begin
            state    <= FS_IDLE;
            deferred <= 1'b0;
            xfer     <= 1'b0;
        end else begin
            state    <= state_nxt;
            xfer     <= fire;
            if (fire) begin
                deferred <= 1'b0;
            end else if (defer_set) begin
                deferred <= 1'b1;
            end
        end
    end

    always_ff @(posedge sys_clk or posedge reset) begin
        if (reset) begin
            shadow <= RESET_VAL;
            q      <= RESET_VAL;
        end else begin
            shadow <= merged;
            if (IMMEDIATE ? wr : fire) begin
                q <= merged;
            end
        end
    end

    assign pending = (state == FS_PENDING);

endmodule

// File: tb/tb_fdsync_shadow.sv
// Bench for fdsync_shadow: shadowed 24-bit instance and an immediate
// 20-bit instance with a partial top lane, checked against a scoreboard.
module tb_fdsync_shadow;

    logic sys_clk = 1'b0;
    always #5 sys_clk = ~sys_clk;

    logic        rst_a, ld_a, sync_a, hold_a;
    logic [2:0]  len_a;
    logic [23:0] d_a, q_a, sh_a;
    logic        pend_a, xfer_a;

    logic        rst_b, ld_b, sync_b, hold_b;
    logic [2:0]  len_b;
    logic [19:0] d_b, q_b, sh_b;
    logic        pend_b, xfer_b;

    fdsync_shadow #(
        .WIDTH     (24),
        .LANE_W    (8),
        .RESET_VAL (24'h000000),
        .IMMEDIATE (1'b0)
    ) u_dut (
        .sys_clk (sys_clk),
        .reset   (rst_a),
        .ld      (ld_a),
        .lane_en (len_a),
        .d       (d_a),
        .sync    (sync_a),
        .hold    (hold_a),
        .q       (q_a),
        .shadow  (sh_a),
        .pending (pend_a),
        .xfer    (xfer_a)
    );

    fdsync_shadow #(
        .WIDTH     (20),
        .LANE_W    (8),
        .RESET_VAL (20'h00000),
        .IMMEDIATE (1'b1)
    ) u_imm (
        .sys_clk (sys_clk),
        .reset   (rst_b),
        .ld      (ld_b),
        .lane_en (len_b),
        .d       (d_b),
        .sync    (sync_b),
        .hold    (hold_b),
        .q       (q_b),
        .shadow  (sh_b),
        .pending (pend_b),
        .xfer    (xfer_b)
    );

    typedef struct {
        logic [23:0] qa;
        logic [23:0] sha;
        logic        pa;
        logic        xa;
        logic [19:0] qb;
        logic [19:0] shb;
        logic        pb;
        logic        xb;
    } exp_t;

    exp_t sb[$];

    logic [23:0] mq_a, msh_a;
    logic        mpend_a, mdef_a, msd_a, mx_a;
    logic [19:0] mq_b, msh_b;

    int n_chk  = 0;
    int n_fail = 0;

    task automatic check(input string tag, input logic [31:0] got,
                         input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic mdl_reset_a();
        mq_a = 24'h0; msh_a = 24'h0;
        mpend_a = 1'b0; mdef_a = 1'b0; msd_a = 1'b1; mx_a = 1'b0;
    endtask

    task automatic mdl_reset_b();
        mq_b = 20'h0; msh_b = 20'h0;
    endtask

    task automatic step(input string tag);
        exp_t        e;
        logic [23:0] mk_a, mg_a;
        logic [19:0] mk_b, mg_b;
        logic        wr, rise, fire;
        if (rst_a) begin
            mdl_reset_a();
        end else begin
            for (int i = 0; i < 24; i++) mk_a[i] = len_a[i / 8];
            wr   = ld_a && (len_a != 3'b000);
            mg_a = wr ? ((msh_a & ~mk_a) | (d_a & mk_a)) : msh_a;
            rise = sync_a && !msd_a;
            fire = mpend_a && !hold_a && (rise || mdef_a);
            if (fire) mdef_a = 1'b0;
            else if (mpend_a && hold_a && rise) mdef_a = 1'b1;
            if (fire) mq_a = mg_a;
            mx_a    = fire;
            mpend_a = fire ? 1'b0 : (wr ? 1'b1 : mpend_a);
            msh_a   = mg_a;
            msd_a   = sync_a;
        end
        if (rst_b) begin
            mdl_reset_b();
        end else begin
            for (int i = 0; i < 20; i++) mk_b[i] = len_b[i / 8];
            if (ld_b && (len_b != 3'b000)) begin
                mg_b  = (msh_b & ~mk_b) | (d_b & mk_b);
                mq_b  = mg_b;
                msh_b = mg_b;
            end
        end
        e.qa = mq_a; e.sha = msh_a; e.pa = mpend_a; e.xa = mx_a;
        e.qb = mq_b; e.shb = msh_b; e.pb = 1'b0;    e.xb = 1'b0;
        sb.push_back(e);
        @(posedge sys_clk);
        #1;
        e = sb.pop_front();
        check({tag, "/q_a"},      q_a,    e.qa);
        check({tag, "/shadow_a"}, sh_a,   e.sha);
        check({tag, "/pend_a"},   pend_a, e.pa);
        check({tag, "/xfer_a"},   xfer_a, e.xa);
        check({tag, "/q_b"},      q_b,    e.qb);
        check({tag, "/shadow_b"}, sh_b,   e.shb);
        check({tag, "/pend_b"},   pend_b, e.pb);
        check({tag, "/xfer_b"},   xfer_b, e.xb);
    endtask

    task automatic wr_a(input logic [2:0] en, input logic [23:0] v);
        ld_a = 1'b1; len_a = en; d_a = v;
    endtask

    task automatic nowr_a();
        ld_a = 1'b0; len_a = 3'b000; d_a = 24'h0;
    endtask

    initial begin
        rst_a = 1'b1; ld_a = 1'b0; len_a = 3'b000; d_a = 24'h0;
        sync_a = 1'b1; hold_a = 1'b0;
        rst_b = 1'b1; ld_b = 1'b0; len_b = 3'b000; d_b = 20'h0;
        sync_b = 1'b0; hold_b = 1'b0;
        mdl_reset_a();
        mdl_reset_b();
        #2;
        step("rst0");
        step("rst1");
        rst_a = 1'b0;
        rst_b = 1'b0;

        for (int i = 0; i < 10; i++) begin
            step("post_rst");
            check("post_rst_xfer", xfer_a, 1'b0);
            check("post_rst_q",    q_a,    24'h000000);
            check("post_rst_pend", pend_a, 1'b0);
        end

        sync_a = 1'b0;
        step("sync_low");
        sync_a = 1'b1;
        step("idle_rise");
        check("idle_rise_xfer", xfer_a, 1'b0);

        wr_a(3'b000, 24'hFFFFFF);
        step("ld_no_lanes");
        check("ld_no_lanes_pend", pend_a, 1'b0);
        check("ld_no_lanes_sh",   sh_a,   24'h000000);

        sync_a = 1'b0;
        wr_a(3'b111, 24'hA5B6C7);
        step("full_wr");
        check("full_wr_pend", pend_a, 1'b1);
        nowr_a();
        step("full_wait");
        sync_a = 1'b1;
        step("full_xfer");
        check("full_xfer_q",    q_a,    24'hA5B6C7);
        check("full_xfer_x",    xfer_a, 1'b1);
        check("full_xfer_pend", pend_a, 1'b0);
        step("full_after");
        check("full_after_x", xfer_a, 1'b0);

        sync_a = 1'b0;
        wr_a(3'b111, 24'h112233);
        step("lane_base");
        wr_a(3'b010, 24'hFFEEFF);
        step("lane_mid");
        check("lane_mid_sh", sh_a, 24'h11EE33);
        nowr_a();
        sync_a = 1'b1;
        step("lane_xfer");
        check("lane_xfer_q", q_a, 24'h11EE33);

        sync_a = 1'b0;
        wr_a(3'b111, 24'hABCDEF);
        step("hold_wr");
        nowr_a();
        hold_a = 1'b1;
        sync_a = 1'b1;
        step("hold_rise");
        check("hold_rise_q",    q_a,    24'h11EE33);
        check("hold_rise_pend", pend_a, 1'b1);
        for (int i = 0; i < 4; i++) begin
            step("hold_wait");
            check("hold_wait_x", xfer_a, 1'b0);
        end
        hold_a = 1'b0;
        step("hold_release");
        check("hold_release_q", q_a,    24'hABCDEF);
        check("hold_release_x", xfer_a, 1'b1);
        step("hold_after");
        check("hold_after_x", xfer_a, 1'b0);

        sync_a = 1'b0;
        wr_a(3'b111, 24'h123456);
        step("coinc_base");
        wr_a(3'b001, 24'h0000AA);
        sync_a = 1'b1;
        step("coinc_xfer");
        check("coinc_q",    q_a,    24'h1234AA);
        check("coinc_pend", pend_a, 1'b0);
        wr_a(3'b100, 24'h770000);
        step("after_xfer_wr");
        check("after_xfer_pend", pend_a, 1'b1);
        check("after_xfer_sh",   sh_a,   24'h7734AA);
        check("after_xfer_q",    q_a,    24'h1234AA);
        nowr_a();

        rst_a = 1'b1;
        #1;
        mdl_reset_a();
        check("async_rst_q",    q_a,    24'h000000);
        check("async_rst_sh",   sh_a,   24'h000000);
        check("async_rst_pend", pend_a, 1'b0);
        check("async_rst_x",    xfer_a, 1'b0);
        step("rst_hold");
        rst_a = 1'b0;
        step("rst_release");
        check("rst_release_q", q_a, 24'h000000);
        sync_a = 1'b0;
        step("rst_sync_low");
        sync_a = 1'b1;
        step("rst_idle_rise");
        check("rst_idle_rise_x", xfer_a, 1'b0);

        ld_b = 1'b1; len_b = 3'b100; d_b = 20'hF0000;
        step("imm_top");
        check("imm_top_q",    q_b,    20'hF0000);
        check("imm_top_pend", pend_b, 1'b0);
        check("imm_top_x",    xfer_b, 1'b0);
        len_b = 3'b001; d_b = 20'h000AB; sync_b = 1'b1; hold_b = 1'b1;
        step("imm_low");
        check("imm_low_q", q_b, 20'hF00AB);
        len_b = 3'b010; d_b = 20'hFCDFF; hold_b = 1'b0; sync_b = 1'b0;
        step("imm_mid");
        check("imm_mid_q", q_b, 20'hFCDAB);
        ld_b = 1'b0;
        sync_b = 1'b1;
        step("imm_sync");
        check("imm_sync_x", xfer_b, 1'b0);

        rst_b = 1'b1;
        #1;
        mdl_reset_b();
        check("imm_rst_q",  q_b,  20'h00000);
        check("imm_rst_sh", sh_b, 20'h00000);
        step("imm_rst_hold");
        rst_b = 1'b0;
        step("imm_rst_release");

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_chk, n_fail);
        $finish;
    end

endmodule
